sha256_msg_packer: RTL and testbench



---
 rtl/sha256_msg_packer_pkg.sv | 20 ++
 rtl/sha256_msg_packer_pad_word.sv | 40 ++++
 rtl/sha256_msg_packer.sv | 156 +++++++++++++++
 tb/tb_sha256_msg_packer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_msg_packer_pkg.sv
// Shared types and constants for the SHA-256 message packer.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DISCARD,
    S_EMIT,
    S_WAIT_CORE
  } state_e;

  localparam int MAX_MSG_BYTES = 55;
  localparam int BUF_BYTES     = 56;
  localparam int BLOCK_WORDS   = 16;
  localparam int LEN_HI_WORD   = 14;
  localparam int LEN_LO_WORD   = 15;

  localparam logic [7:0] PAD_BYTE = 8'h80;

endpackage

// File: rtl/sha256_msg_packer_pad_word.sv
// Builds padded word w of the single 512-bit block from the byte buffer.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [BUF_BYTES*8-1:0] buf_i,
  input  logic [5:0]             cnt_i,
  input  logic [3:0]             w_i,
  output logic [31:0]            word_o
);

  logic [511:0] ext;
  logic [5:0]   k;
  logic [7:0]   b;

  assign ext = {64'b0, buf_i};

  always_comb begin
    word_o = '0;
    k      = '0;
    b      = '0;
    for (int j = 0; j < 4; j++) begin
      k = {w_i, 2'(j)};
      if (k < cnt_i) begin
        b = ext[{k, 3'b000} +: 8];
      end else if (k == cnt_i) begin
        b = PAD_BYTE;
      end else begin
        b = 8'h00;
      end
      word_o[31-8*j -: 8] = b;
    end
    // Length lives in the last two words; only 9 bits can be nonzero.
    if (w_i == 4'(LEN_HI_WORD)) begin
      word_o = '0;
    end else if (w_i == 4'(LEN_LO_WORD)) begin
      word_o = {23'b0, cnt_i, 3'b000};
    end
  end

endmodule

// File: rtl/sha256_msg_packer.sv
// Packs a 1..55 byte message into one padded SHA-256 block of 16 words.
// Optional idle timeout ending a message: define SHA_MP_TIMEOUT_EN.
module sha256_msg_packer
  import sha256_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int WORD_GAP    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_dv,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_last,
  input  logic                  core_done,
  output logic                  MP_dv,
  output logic [DATA_WIDTH-1:0] message_in,
  output logic                  busy,
  output logic                  len_err
);

  localparam int GW = $clog2(WORD_GAP) + 1;

  if (DATA_WIDTH != 32 || WORD_GAP < 3 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
    $error("sha256_msg_packer: unsupported parameters");
  end

  state_e                 state_q, state_d;
  logic [5:0]             cnt_q, cnt_d;
  logic [3:0]             word_q, word_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   mp_dv_q, mp_dv_d;
  logic [DATA_WIDTH-1:0]  msg_q, msg_d;
  logic                   len_err_q, len_err_d;
  logic [BUF_BYTES*8-1:0] buf_q, buf_d;
  logic [31:0]            pad_word;

`ifdef SHA_MP_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
`endif

  sha256_pad_word u_pad (
    .buf_i  (buf_q),
    .cnt_i  (cnt_q),
    .w_i    (word_q),
    .word_o (pad_word)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    gap_d     = gap_q;
    mp_dv_d   = 1'b0;
    msg_d     = msg_q;
    len_err_d = len_err_q;
    buf_d     = buf_q;
`ifdef SHA_MP_TIMEOUT_EN
    idle_d    = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_dv) begin
          buf_d[7:0] = rx_byte;
          cnt_d      = 6'd1;
          len_err_d  = 1'b0;
          word_d     = '0;
          gap_d      = '0;
          state_d    = rx_last ? S_EMIT : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (rx_dv) begin
          if (cnt_q < 6'(MAX_MSG_BYTES)) begin
            buf_d[{cnt_q, 3'b000} +: 8] = rx_byte;
            cnt_d = cnt_q + 6'd1;
            if (rx_last) state_d = S_EMIT;
          end else begin
            // Overflow byte is dropped; a terminator here ends at once.
            len_err_d = 1'b1;
            state_d   = rx_last ? S_IDLE : S_DISCARD;
          end
        end
`ifdef SHA_MP_TIMEOUT_EN
        else begin
          idle_d = idle_q + 16'd1;
          if (idle_d == 16'(TIMEOUT_CYC)) state_d = S_EMIT;
        end
`endif
      end
      S_DISCARD: begin
        if (rx_dv && rx_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (gap_q == '0) begin
          mp_dv_d = 1'b1;
          msg_d   = pad_word;
          gap_d   = GW'(WORD_GAP - 1);
          word_d  = word_q + 4'd1;
          if (word_q == 4'(BLOCK_WORDS - 1)) state_d = S_WAIT_CORE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_WAIT_CORE: begin
        if (core_done) begin
          cnt_d   = '0;
          word_d  = '0;
          gap_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      gap_q     <= '0;
      mp_dv_q   <= 1'b0;
      msg_q     <= '0;
      len_err_q <= 1'b0;
`ifdef SHA_MP_TIMEOUT_EN
      idle_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      gap_q     <= gap_d;
      mp_dv_q   <= mp_dv_d;
      msg_q     <= msg_d;
      len_err_q <= len_err_d;
`ifdef SHA_MP_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign MP_dv      = mp_dv_q;
  assign message_in = msg_q;
  assign len_err    = len_err_q;
  assign busy       = (state_q == S_EMIT) || (state_q == S_WAIT_CORE);

endmodule

// File: tb/tb_sha256_msg_packer.sv
// Randomized self-checking bench for sha256_msg_packer against a padding model.
module tb_sha256_msg_packer;

  localparam int WORD_GAP = 4;
  localparam int TO_CYC   = 16;

  typedef logic [7:0]  bytes_t [$];
  typedef logic [31:0] blk_t [16];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_last = 1'b0;
  logic        core_done = 1'b0;
  logic        MP_dv;
  logic [31:0] message_in;
  logic        busy;
  logic        len_err;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [$];
  int          blk_idx = 0;
  int          npulse = 0;
  longint      cyc = 0;
  longint      last_cyc = 0;
  logic [31:0] e_w;

  sha256_msg_packer #(
    .DATA_WIDTH  (32),
    .WORD_GAP    (WORD_GAP),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_dv      (rx_dv),
    .rx_byte    (rx_byte),
    .rx_last    (rx_last),
    .core_done  (core_done),
    .MP_dv      (MP_dv),
    .message_in (message_in),
    .busy       (busy),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Padded block straight from the message: bytes, 0x80, zeros, 64-bit bit length.
  function automatic blk_t model_block(bytes_t m);
    logic [7:0]  b [64];
    logic [63:0] bits;
    blk_t        w;
    foreach (b[i]) b[i] = 8'h00;
    foreach (m[i]) b[i] = m[i];
    b[m.size()] = 8'h80;
    bits = 64'(m.size()) * 64'd8;
    for (int i = 0; i < 8; i++) b[56+i] = bits[63-8*i -: 8];
    for (int i = 0; i < 16; i++)
      w[i] = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
    return w;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (MP_dv === 1'b1) begin
      npulse++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_mp_dv: got pulse with word %h, expected none",
                 message_in);
      end else begin
        e_w = exp_q.pop_front();
        if (message_in !== e_w) begin
          errors++;
          $display("FAIL word%0d: got %h, expected %h", blk_idx, message_in, e_w);
        end
        if (blk_idx != 0) begin
          checks++;
          if (cyc - last_cyc != WORD_GAP) begin
            errors++;
            $display("FAIL gap%0d: got %0d cycles, expected %0d",
                     blk_idx, cyc - last_cyc, WORD_GAP);
          end
        end
        last_cyc = cyc;
        blk_idx  = (blk_idx + 1) % 16;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(bytes_t m, bit with_last);
    foreach (m[i]) begin
      tick($urandom_range(0, 2));
      rx_dv   = 1'b1;
      rx_byte = m[i];
      rx_last = with_last && (i == m.size() - 1);
      tick();
      rx_dv   = 1'b0;
      rx_last = 1'b0;
    end
  endtask

  task automatic expect_block(bytes_t m);
    blk_t w;
    w = model_block(m);
    foreach (w[i]) exp_q.push_back(w[i]);
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words pending, expected 0",
               name, exp_q.size());
      exp_q.delete();
      blk_idx = 0;
    end
  endtask

  task automatic finish_core(string name);
    tick(2);
    chk({name, "_busy_wait"}, 32'(busy), 32'd1);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    chk({name, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_msg(string name, bytes_t m);
    expect_block(m);
    send(m, 1'b1);
    wait_drain(name);
    finish_core(name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t abc, four, aa, ab, lng, m;
    blk_t   w;
    int     n0, n;

    abc  = '{8'h61, 8'h62, 8'h63};
    four = '{8'h01, 8'h02, 8'h03, 8'h04};
    ab   = '{8'h61, 8'h62};
    aa   = {};
    repeat (55) aa.push_back(8'hAA);

    rst_n = 1'b0;
    tick(3);
    chk("rst_mp_dv", 32'(MP_dv), 32'd0);
    chk("rst_msg", message_in, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    rst_n = 1'b1;
    tick(2);

    w = model_block(abc);
    chk("model_abc_w0", w[0], 32'h61626380);
    chk("model_abc_w1", w[1], 32'h0);
    chk("model_abc_w14", w[14], 32'h0);
    chk("model_abc_w15", w[15], 32'h18);
    w = model_block(four);
    chk("model_four_w0", w[0], 32'h01020304);
    chk("model_four_w1", w[1], 32'h80000000);
    chk("model_four_w15", w[15], 32'h20);
    w = model_block(aa);
    chk("model_aa_w12", w[12], 32'hAAAAAAAA);
    chk("model_aa_w13", w[13], 32'hAAAAAA80);
    chk("model_aa_w15", w[15], 32'h1B8);
    w = model_block(ab);
    chk("model_ab_w0", w[0], 32'h61628000);
    chk("model_ab_w15", w[15], 32'h10);

    expect_block(abc);
    send(abc, 1'b1);
    wait_drain("abc");
    send('{8'h11, 8'h22, 8'h33}, 1'b1);
    chk("wait_drop_len_err", 32'(len_err), 32'd0);
    finish_core("abc");
    run_msg("abc_after_drop", abc);

    run_msg("four", four);
    run_msg("aa55", aa);
    chk("aa55_len_err", 32'(len_err), 32'd0);

    lng = {};
    repeat (60) lng.push_back(8'($urandom));
    send(lng[0:54], 1'b0);
    chk("ovf_55_len_err", 32'(len_err), 32'd0);
    send(lng[55:55], 1'b0);
    chk("ovf_56_len_err", 32'(len_err), 32'd1);
    send(lng[56:59], 1'b1);
    tick(2);
    chk("ovf_busy", 32'(busy), 32'd0);
    chk("ovf_len_err_sticky", 32'(len_err), 32'd1);
    run_msg("abc_after_ovf", abc);
    chk("abc_clears_len_err", 32'(len_err), 32'd0);

    send(lng[0:55], 1'b1);
    tick(2);
    chk("last56_len_err", 32'(len_err), 32'd1);
    chk("last56_busy", 32'(busy), 32'd0);
    run_msg("abc_after_last56", abc);

    for (int t = 0; t < 12; t++) begin
      m = {};
      n = $urandom_range(1, 55);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      run_msg($sformatf("rand%0d", t), m);
    end

    send(ab, 1'b0);
`ifdef SHA_MP_TIMEOUT_EN
    expect_block(ab);
    wait_drain("timeout_ab");
    finish_core("timeout_ab");
`else
    tick(40);
    chk("no_timeout_busy", 32'(busy), 32'd0);
    expect_block(abc);
    send('{8'h63}, 1'b1);
    wait_drain("ab_then_c");
    finish_core("ab_then_c");
`endif

    expect_block(abc);
    n0 = npulse;
    send(abc, 1'b1);
    n = 0;
    while (npulse < n0 + 5 && n < 200) begin
      tick();
      n++;
    end
    chk("pre_reset_pulses", 32'(npulse - n0), 32'd5);
    rst_n = 1'b0;
    exp_q.delete();
    blk_idx = 0;
    tick();
    chk("midrst_mp_dv", 32'(MP_dv), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_msg", message_in, 32'd0);
    rst_n = 1'b1;
    n0 = npulse;
    tick(100);
    chk("midrst_no_pulse", 32'(npulse - n0), 32'd0);
    run_msg("abc_after_rst", abc);

    tick(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
